// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the fetch stage (package fetch_pkg)
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  localparam logic [21:0] NOP_INSTR  = 22'h0;
  localparam logic [21:0] PC_STEP    = 22'd4;
  localparam logic [21:0] PC8_OFFSET = 22'd8;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/acknowledge bundle
interface fetch_stage_if;
  import fetch_pkg::*;

  logic        imem_req;
  logic [21:0] imem_addr;
  logic [21:0] imem_rdata;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);

endinterface

// File: rtl/fetch_stage_if_id_register.sv
// rtl/fetch_stage_if_id_register.sv - IF/ID pipeline register with flush (priority) and load
module if_id_register
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [21:0] instr_in,
  input  logic [21:0] pc8_in,
  output logic [21:0] instruction,
  output logic [21:0] pc_plus_8,
  output logic        valid
);

  // flush only invalidates; pc_plus_8 is meaningless while valid is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_INSTR;
      pc_plus_8   <= 22'h0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= instr_in;
      pc_plus_8   <= pc8_in;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM, PC and skid; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [21:0] RESET_PC = 22'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               pc_src_in,
  input  logic [21:0]        branch_target_in,
  fetch_stage_if.master      imem,
  output logic [21:0]        instruction_decode_out,
  output logic [21:0]        pc_plus_8_out,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_count,
`endif
  output logic               valid_d
);

  fetch_state_t state;
  logic [21:0]  pc;
  logic [21:0]  skid;
  logic         accept_req;
  logic         release_hold;
  logic         load;
  logic [21:0]  load_word;

  assign imem.imem_req  = (state == S_REQ);
  assign imem.imem_addr = pc;

  assign accept_req   = (state == S_REQ) && imem.imem_ack && !stall_d && !pc_src_in;
  assign release_hold = (state == S_HOLD) && !stall_d && !pc_src_in;
  assign load         = accept_req || release_hold;
  assign load_word    = (state == S_HOLD) ? skid : imem.imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      skid  <= NOP_INSTR;
    end else if (pc_src_in) begin
      // an un-acked request in flight must have its late ack swallowed in S_DROP
      pc    <= branch_target_in;
      skid  <= NOP_INSTR;
      state <= (state == S_HOLD || imem.imem_ack) ? S_REQ : S_DROP;
    end else begin
      case (state)
        S_REQ: begin
          if (imem.imem_ack) begin
            if (!stall_d) begin
              pc <= pc + PC_STEP;
            end else begin
              skid  <= imem.imem_rdata;
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_d) begin
            pc    <= pc + PC_STEP;
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem.imem_ack) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_id_register u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .flush       (pc_src_in || flush_d),
    .instr_in    (load_word),
    .pc8_in      (pc + PC8_OFFSET),
    .instruction (instruction_decode_out),
    .pc_plus_8   (pc_plus_8_out),
    .valid       (valid_d)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 16'h0;
      stall_count <= 16'h0;
    end else begin
      if (load && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      if (state == S_HOLD && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
